// File: rtl/decode_writeback_if.sv
// Decode/writeback stage bundle: D pipe regs, forwarding and W write ports in,
// source IDs, E pipe regs and debug read data out.
interface decode_writeback_if;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB, D_stat;
    logic [63:0] D_valC, D_valP;
    logic        E_bubble;
    logic [3:0]  e_dstE;
    logic [63:0] e_valE;
    logic [3:0]  M_dstE, M_dstM;
    logic [63:0] M_valE, m_valM;
    logic [3:0]  W_dstE, W_dstM;
    logic [63:0] W_valE, W_valM;
    logic [3:0]  d_srcA, d_srcB;
    logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB, E_stat;
    logic [63:0] E_valC, E_valA, E_valB;
    logic [3:0]  dbg_rsel;
    logic [63:0] dbg_rdata;

    modport master (
        output D_icode, D_ifun, D_rA, D_rB, D_stat, D_valC, D_valP,
        output E_bubble, e_dstE, e_valE, M_dstE, M_dstM, M_valE, m_valM,
        output W_dstE, W_dstM, W_valE, W_valM, dbg_rsel,
        input  d_srcA, d_srcB, E_icode, E_ifun, E_dstE, E_dstM,
        input  E_srcA, E_srcB, E_stat, E_valC, E_valA, E_valB, dbg_rdata
    );

    modport slave (
        input  D_icode, D_ifun, D_rA, D_rB, D_stat, D_valC, D_valP,
        input  E_bubble, e_dstE, e_valE, M_dstE, M_dstM, M_valE, m_valM,
        input  W_dstE, W_dstM, W_valE, W_valM, dbg_rsel,
        output d_srcA, d_srcB, E_icode, E_ifun, E_dstE, E_dstM,
        output E_srcA, E_srcB, E_stat, E_valC, E_valA, E_valB, dbg_rdata
    );
endinterface

// File: rtl/decode_writeback.sv
// Y86-64 decode stage with register file and W-stage write port.
// Define DECODE_FWD_EN to build the e/M/W operand forwarding chain.
module decode_writeback #(
    parameter logic [3:0] RSP_ID = 4'h4,
    parameter logic [3:0] RNONE  = 4'hF
) (
    input logic               clk,
    input logic               rst,
    decode_writeback_if.slave bus
);

    logic [63:0] rf [15];
    logic [3:0]  src_a, src_b, dst_e, dst_m;
    logic [63:0] val_a, val_b;

    function automatic logic [63:0] rf_rd(input logic [3:0] id);
        return (id == RNONE) ? 64'd0 : rf[id];
    endfunction

    // Operand for a non-F source; a match implies the producer dst is not F.
    function automatic logic [63:0] operand(input logic [3:0] src);
`ifdef DECODE_FWD_EN
        if (src == bus.e_dstE)      return bus.e_valE;
        else if (src == bus.M_dstM) return bus.m_valM;
        else if (src == bus.M_dstE) return bus.M_valE;
        else if (src == bus.W_dstM) return bus.W_valM;
        else if (src == bus.W_dstE) return bus.W_valE;
`endif
        return rf_rd(src);
    endfunction

    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        unique case (bus.D_icode)
            4'h2: begin src_a = bus.D_rA; dst_e = bus.D_rB; end
            4'h3: dst_e = bus.D_rB;
            4'h4: begin src_a = bus.D_rA; src_b = bus.D_rB; end
            4'h5: begin src_b = bus.D_rB; dst_m = bus.D_rA; end
            4'h6: begin
                src_a = bus.D_rA;
                src_b = bus.D_rB;
                dst_e = bus.D_rB;
            end
            4'h8: begin src_b = RSP_ID; dst_e = RSP_ID; end
            4'h9: begin
                src_a = RSP_ID;
                src_b = RSP_ID;
                dst_e = RSP_ID;
            end
            4'hA: begin
                src_a = bus.D_rA;
                src_b = RSP_ID;
                dst_e = RSP_ID;
            end
            4'hB: begin
                src_a = RSP_ID;
                src_b = RSP_ID;
                dst_e = RSP_ID;
                dst_m = bus.D_rA;
            end
            default: ;
        endcase
    end

    always_comb begin
        val_a = 64'd0;
        if (bus.D_icode == 4'h7 || bus.D_icode == 4'h8)
            val_a = bus.D_valP;
        else if (src_a != RNONE)
            val_a = operand(src_a);
    end

    always_comb begin
        val_b = 64'd0;
        if (src_b != RNONE)
            val_b = operand(src_b);
    end

    assign bus.d_srcA    = src_a;
    assign bus.d_srcB    = src_b;
    assign bus.dbg_rdata = rf_rd(bus.dbg_rsel);

    // M write is issued last so it wins when both ports hit the same ID.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 15; i++)
                rf[i] <= 64'd0;
        end else begin
            if (bus.W_dstE != RNONE)
                rf[bus.W_dstE] <= bus.W_valE;
            if (bus.W_dstM != RNONE)
                rf[bus.W_dstM] <= bus.W_valM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.E_bubble) begin
            bus.E_icode <= 4'h1;
            bus.E_ifun  <= 4'h0;
            bus.E_dstE  <= RNONE;
            bus.E_dstM  <= RNONE;
            bus.E_srcA  <= RNONE;
            bus.E_srcB  <= RNONE;
            bus.E_valC  <= 64'd0;
            bus.E_valA  <= 64'd0;
            bus.E_valB  <= 64'd0;
            bus.E_stat  <= 4'b0001;
        end else begin
            bus.E_icode <= bus.D_icode;
            bus.E_ifun  <= bus.D_ifun;
            bus.E_dstE  <= dst_e;
            bus.E_dstM  <= dst_m;
            bus.E_srcA  <= src_a;
            bus.E_srcB  <= src_b;
            bus.E_valC  <= bus.D_valC;
            bus.E_valA  <= val_a;
            bus.E_valB  <= val_b;
            bus.E_stat  <= bus.D_stat;
        end
    end

endmodule

// File: tb/tb_decode_writeback.sv
// Randomized bench for decode_writeback against an ISA-level reference model.
// Honours DECODE_FWD_EN the same way as the design build.
module tb_decode_writeback;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_writeback_if bus ();

    decode_writeback dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [63:0] mreg [15];
    logic [3:0]  x_icode, x_ifun, x_dste, x_dstm, x_srca, x_srcb, x_stat;
    logic [63:0] x_valc, x_vala, x_valb;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] m_srca(input logic [3:0] ic, ra);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
        if (ic inside {4'h9, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_srcb(input logic [3:0] ic, rb);
        if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_dste(input logic [3:0] ic, rb);
        if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_dstm(input logic [3:0] ic, ra);
        return (ic inside {4'h5, 4'hB}) ? ra : 4'hF;
    endfunction

    function automatic logic [63:0] m_read(input logic [3:0] id);
        return (id == 4'hF) ? 64'd0 : mreg[id];
    endfunction

    // First producer in pipeline-age order that targets src wins.
    function automatic logic [63:0] m_operand(input logic [3:0] src);
        logic [3:0]  ids  [5];
        logic [63:0] vals [5];
        ids  = '{bus.e_dstE, bus.M_dstM, bus.M_dstE, bus.W_dstM, bus.W_dstE};
        vals = '{bus.e_valE, bus.m_valM, bus.M_valE, bus.W_valM, bus.W_valE};
        if (src == 4'hF) return 64'd0;
`ifdef DECODE_FWD_EN
        foreach (ids[i])
            if (ids[i] != 4'hF && ids[i] == src) return vals[i];
`else
        if (ids[0] == 4'h0 && vals[0] == 64'd0) return m_read(src);
`endif
        return m_read(src);
    endfunction

    task automatic m_bubble();
        x_icode = 4'h1; x_ifun = 4'h0; x_dste = 4'hF; x_dstm = 4'hF;
        x_srca = 4'hF;  x_srcb = 4'hF; x_stat = 4'b0001;
        x_valc = 64'd0; x_vala = 64'd0; x_valb = 64'd0;
    endtask

    task automatic step();
        logic [3:0] ic;
        @(posedge clk);
        ic = bus.D_icode;
        if (rst) begin
            foreach (mreg[i]) mreg[i] = 64'd0;
            m_bubble();
        end else begin
            if (bus.E_bubble) m_bubble();
            else begin
                x_icode = ic;
                x_ifun  = bus.D_ifun;
                x_stat  = bus.D_stat;
                x_valc  = bus.D_valC;
                x_srca  = m_srca(ic, bus.D_rA);
                x_srcb  = m_srcb(ic, bus.D_rB);
                x_dste  = m_dste(ic, bus.D_rB);
                x_dstm  = m_dstm(ic, bus.D_rA);
                x_vala  = (ic inside {4'h7, 4'h8}) ? bus.D_valP
                                                   : m_operand(x_srca);
                x_valb  = m_operand(x_srcb);
            end
            if (bus.W_dstE != 4'hF) mreg[bus.W_dstE] = bus.W_valE;
            if (bus.W_dstM != 4'hF) mreg[bus.W_dstM] = bus.W_valM;
        end
        @(negedge clk);
        chk("E_icode", bus.E_icode, x_icode);
        chk("E_ifun",  bus.E_ifun,  x_ifun);
        chk("E_dstE",  bus.E_dstE,  x_dste);
        chk("E_dstM",  bus.E_dstM,  x_dstm);
        chk("E_srcA",  bus.E_srcA,  x_srca);
        chk("E_srcB",  bus.E_srcB,  x_srcb);
        chk("E_stat",  bus.E_stat,  x_stat);
        chk("E_valC",  bus.E_valC,  x_valc);
        chk("E_valA",  bus.E_valA,  x_vala);
        chk("E_valB",  bus.E_valB,  x_valb);
        chk("dbg",     bus.dbg_rdata, m_read(bus.dbg_rsel));
    endtask

    task automatic check_comb();
        #1;
        chk("d_srcA", bus.d_srcA, m_srca(bus.D_icode, bus.D_rA));
        chk("d_srcB", bus.d_srcB, m_srcb(bus.D_icode, bus.D_rB));
        chk("dbg_c",  bus.dbg_rdata, m_read(bus.dbg_rsel));
    endtask

    task automatic quiet();
        bus.E_bubble = 1'b0;
        bus.e_dstE = 4'hF; bus.e_valE = 64'd0;
        bus.M_dstE = 4'hF; bus.M_valE = 64'd0;
        bus.M_dstM = 4'hF; bus.m_valM = 64'd0;
        bus.W_dstE = 4'hF; bus.W_valE = 64'd0;
        bus.W_dstM = 4'hF; bus.W_valM = 64'd0;
    endtask

    task automatic set_d(input logic [3:0] ic, ra, rb,
                         input logic [63:0] vc, vp);
        bus.D_icode = ic; bus.D_ifun = 4'h0;
        bus.D_rA = ra;    bus.D_rB = rb;
        bus.D_valC = vc;  bus.D_valP = vp;
        bus.D_stat = 4'b0001;
    endtask

    function automatic logic [3:0] rnd_id();
        if ($urandom_range(0, 3) == 0) return 4'hF;
        return 4'($urandom_range(0, 14));
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        rst = 1'b1;
        quiet();
        set_d(4'h1, 4'hF, 4'hF, 64'd0, 64'd0);
        bus.dbg_rsel = 4'h0;
        @(negedge clk);
        bus.W_dstE = 4'h5; bus.W_valE = 64'hDEAD;
        step();
        rst = 1'b0;
        quiet();
        chk("rst_icode", bus.E_icode, 64'h1);
        chk("rst_stat",  bus.E_stat,  64'h1);
        for (int i = 0; i < 15; i++) begin
            bus.dbg_rsel = 4'(i);
            #1 chk("rst_reg", bus.dbg_rdata, 64'd0);
        end

        bus.W_dstE = 4'h3; bus.W_valE = 64'h100;
        step();
        quiet();
        bus.dbg_rsel = 4'h3;
        #1 chk("wb_reg3", bus.dbg_rdata, 64'h100);

        set_d(4'h3, 4'hF, 4'h2, 64'h200, 64'h10);
        check_comb();
        step();
        chk("irm_dstE", bus.E_dstE, 64'h2);
        chk("irm_valC", bus.E_valC, 64'h200);
        chk("irm_srcA", bus.E_srcA, 64'hF);

        set_d(4'h1, 4'hF, 4'hF, 64'd0, 64'd0);
        bus.W_dstE = 4'h2; bus.W_valE = 64'd5;
        step();
        quiet();
        set_d(4'h6, 4'h2, 4'h3, 64'd0, 64'd0);
        bus.e_dstE = 4'h2; bus.e_valE = 64'hAA;
        bus.W_dstE = 4'h2; bus.W_valE = 64'hBB;
        check_comb();
        step();
`ifdef DECODE_FWD_EN
        chk("fwd_valA", bus.E_valA, 64'hAA);
`else
        chk("fwd_valA", bus.E_valA, 64'd5);
`endif
        quiet();

        set_d(4'h1, 4'hF, 4'hF, 64'd0, 64'd0);
        bus.W_dstE = 4'h4; bus.W_valE = 64'h10;
        bus.W_dstM = 4'h4; bus.W_valM = 64'h20;
        step();
        quiet();
        bus.dbg_rsel = 4'h4;
        #1 chk("same_id", bus.dbg_rdata, 64'h20);

        set_d(4'hB, 4'h1, 4'hF, 64'd0, 64'd0);
        check_comb();
        step();
        chk("pop_srcA", bus.E_srcA, 64'h4);
        chk("pop_dstM", bus.E_dstM, 64'h1);
        chk("pop_valA", bus.E_valA, 64'h20);
        chk("pop_valB", bus.E_valB, 64'h20);

        set_d(4'h8, 4'hF, 4'hF, 64'h40, 64'h30);
        bus.E_bubble = 1'b1;
        step();
        chk("call_bub", bus.E_icode, 64'h1);
        chk("call_bva", bus.E_valA, 64'd0);
        bus.E_bubble = 1'b0;
        step();
        chk("call_valA", bus.E_valA, 64'h30);
        chk("call_dstE", bus.E_dstE, 64'h4);

        for (int n = 0; n < 500; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            bus.E_bubble = ($urandom_range(0, 7) == 0);
            set_d(4'($urandom_range(0, 15)), rnd_id(), rnd_id(),
                  rnd64(), rnd64());
            bus.D_ifun = 4'($urandom_range(0, 15));
            bus.D_stat = 4'($urandom_range(0, 15));
            bus.e_dstE = rnd_id(); bus.e_valE = rnd64();
            bus.M_dstE = rnd_id(); bus.M_valE = rnd64();
            bus.M_dstM = rnd_id(); bus.m_valM = rnd64();
            bus.W_dstE = rnd_id(); bus.W_valE = rnd64();
            bus.W_dstM = rnd_id(); bus.W_valM = rnd64();
            bus.dbg_rsel = 4'($urandom_range(0, 15));
            check_comb();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
